// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder (prio_enc_seq).
package prio_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Index width for an n-entry request vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set index at/after start_i (with wrap), index = N-1-bit.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         one_hot_o
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start_i) + k;
            if (idx >= N) idx = idx - N;
            if (!found && mask_i[N-1-idx]) begin
                found = 1'b1;
                idx_o = W'(idx);
            end
        end
    end

    assign one_hot_o = (mask_i != '0) && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: captures a request vector, then emits one index per handshake.
// Define PRIO_ENC_RR_EN for round-robin search order; default build is fixed priority.
module prio_enc_seq
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] start_idx;
    logic [W-1:0] pick_idx;
    logic         pick_one;
    logic         out_hs;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    assign start_idx = ptr_q;
`else
    assign start_idx = '0;
`endif

    prio_pick #(.N(N)) u_pick (
        .mask_i    (pending_q),
        .start_i   (start_idx),
        .idx_o     (pick_idx),
        .one_hot_o (pick_one)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SERVE);
    assign busy      = (pending_q != '0);
    assign out       = out_valid ? pick_idx : '0;
    assign out_last  = out_valid & pick_one;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                // A zero vector is accepted and dropped without leaving IDLE.
                if (in_valid && in != '0) begin
                    pending_d = in;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(N'(1) << (N - 1 - int'(pick_idx)));
                    if (pick_one) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PRIO_ENC_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (out_hs) ptr_d = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
    end
`endif

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
`ifdef PRIO_ENC_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
`ifdef PRIO_ENC_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

endmodule
